// File: rtl/reg_monitor_7seg.sv
// -----------------------------------------------------------------------------
// reg_monitor_7seg
//
// Debug display stage for the CPU register-inspection port. It walks reg_sel
// through the 32 registers, either automatically or one button press at a
// time. It snapshots reg_data and shows the value as 8 hex digits on a
// multiplexed, active-low 7-segment display.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high reset
//   mode_auto  in   1   1 = auto-step registers, 0 = manual step
//   step_btn   in   1   raw asynchronous push-button, active-high
//   freeze     in   1   1 = hold snapshot and register index
//   reg_sel    out  5   register index to the computer
//   reg_data   in   32  register value (combinational on reg_sel)
//   disp_an    out  8   digit enables, active-low, bit0 = rightmost digit
//   disp_seg   out  8   {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module reg_monitor_7seg #(
    parameter int SCAN_DIV = 50000,
    parameter int STEP_DIV = 50000000,
    parameter int DB_LEN   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_auto,
    input  logic        step_btn,
    input  logic        freeze,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    // Step button synchroniser and edge detector
    logic [DB_LEN-1:0] r_sync;
    logic [DB_LEN-1:0] r_fill;
    logic              r_prev;
    logic              r_armed;
    logic              r_step_pulse;

    // r_fill marks when the synchroniser output reflects the real pin after
    // reset. r_armed is only set once a genuine low level has been seen, so a
    // button held through reset never produces a pulse on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync       <= '0;
            r_fill       <= '0;
            r_prev       <= 1'b0;
            r_armed      <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_sync       <= {r_sync[DB_LEN-2:0], step_btn};
            r_fill       <= {r_fill[DB_LEN-2:0], 1'b1};
            r_prev       <= r_sync[DB_LEN-1];
            r_armed      <= r_armed | (r_fill[DB_LEN-1] & ~r_sync[DB_LEN-1]);
            r_step_pulse <= r_armed & r_sync[DB_LEN-1] & ~r_prev;
        end
    end

    // Register index and auto-step timer
    logic [4:0]        r_idx;
    logic [STEP_W-1:0] r_step_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= 5'd0;
            r_step_cnt <= '0;
        end else if (!freeze) begin
            if (!mode_auto) begin
                r_step_cnt <= '0;
                if (r_step_pulse) begin
                    r_idx <= r_idx + 5'd1;
                end
            end else if (r_step_pulse || (r_step_cnt == STEP_W'(STEP_DIV - 1))) begin
                // A button pulse landing on terminal count still gives one step
                r_idx      <= r_idx + 5'd1;
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
        end
    end

    assign reg_sel = r_idx;

    // Snapshot of the selected register
    logic [31:0] r_snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= 32'd0;
        end else if (!freeze) begin
            r_snap <= reg_data;
        end
    end

    // Digit scan, independent of freeze and mode
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [2:0]        r_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Hex font lookup for the nibble of the active digit
    logic [3:0] w_nibble;
    logic [6:0] w_font;
    logic       w_dp;

    assign w_nibble = r_snap[{r_digit, 2'b00} +: 4];
    assign w_dp     = ~((r_digit == 3'd0) & mode_auto);

    always_comb begin
        w_font = 7'h7F;
        case (w_nibble)
            4'h0: w_font = 7'h40;
            4'h1: w_font = 7'h79;
            4'h2: w_font = 7'h24;
            4'h3: w_font = 7'h30;
            4'h4: w_font = 7'h19;
            4'h5: w_font = 7'h12;
            4'h6: w_font = 7'h02;
            4'h7: w_font = 7'h78;
            4'h8: w_font = 7'h00;
            4'h9: w_font = 7'h10;
            4'hA: w_font = 7'h08;
            4'hB: w_font = 7'h03;
            4'hC: w_font = 7'h46;
            4'hD: w_font = 7'h21;
            4'hE: w_font = 7'h06;
            4'hF: w_font = 7'h0E;
            default: w_font = 7'h7F;
        endcase
    end

    // Registered output stage; reset value shows "0" on digit 0, dp off
    logic [7:0] r_an;
    logic [7:0] r_seg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 8'hFE;
            r_seg <= 8'hC0;
        end else begin
            r_an  <= ~(8'b1 << r_digit);
            r_seg <= {w_dp, w_font};
        end
    end

    assign disp_an  = r_an;
    assign disp_seg = r_seg;

endmodule

// File: tb/tb_reg_monitor_7seg.sv
// -----------------------------------------------------------------------------
// tb_reg_monitor_7seg
//
// Bench for reg_monitor_7seg with short dividers. A register file array plays
// the computer; the expected display is derived from the edge count since
// reset release (digit slot) and the register value captured on the previous
// unfrozen edge (segment font). Index behaviour is checked against edge
// counts worked out from the button latency and the auto-step period.
// -----------------------------------------------------------------------------
module tb_reg_monitor_7seg;

    localparam int SCAN_DIV = 4;
    localparam int STEP_DIV = 16;
    localparam int DB_LEN   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_auto;
    logic        step_btn;
    logic        freeze;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [7:0]  disp_an;
    logic [7:0]  disp_seg;

    logic [31:0] regs [32];
    logic        use_ovr;
    logic [31:0] ovr_val;

    assign reg_data = use_ovr ? ovr_val : regs[reg_sel];

    always #5 clk = ~clk;

    reg_monitor_7seg #(
        .SCAN_DIV (SCAN_DIV),
        .STEP_DIV (STEP_DIV),
        .DB_LEN   (DB_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_auto (mode_auto),
        .step_btn  (step_btn),
        .freeze    (freeze),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .disp_an   (disp_an),
        .disp_seg  (disp_seg)
    );

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_edge   = 0;
    int          exp_idx  = 0;
    logic [31:0] model_snap = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: capture what the DUT will see at the edge, advance, then
    // compare the display against the slot/value it should be showing.
    task automatic tick();
        logic [31:0] pre_data;
        logic        pre_frz;
        logic        pre_mode;
        logic [31:0] old_snap;
        logic [7:0]  exp_an;
        logic [7:0]  exp_seg;
        int          d;
        pre_data = use_ovr ? ovr_val : regs[reg_sel];
        pre_frz  = freeze;
        pre_mode = mode_auto;
        old_snap = model_snap;
        @(posedge clk);
        #1;
        n_edge++;
        d = ((n_edge - 1) / SCAN_DIV) % 8;
        if (!pre_frz) model_snap = pre_data;
        exp_an  = ~(8'b1 << d);
        exp_seg = {!((d == 0) && pre_mode), font[old_snap[4*d +: 4]]};
        check("scan_an", disp_an, exp_an);
        check("scan_seg", disp_seg, exp_seg);
    endtask

    task automatic do_reset(input logic hold_btn);
        #2;
        reset    = 1'b1;
        step_btn = hold_btn;
        #1;
        check("rst_an", disp_an, 8'hFE);
        check("rst_seg", disp_seg, 8'hC0);
        check("rst_sel", reg_sel, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        n_edge     = 0;
        model_snap = 32'd0;
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        repeat (10) tick();
    endtask

    // Reassemble the 32-bit value by decoding every digit slot once.
    task automatic read_display(output logic [31:0] val);
        logic [7:0] an_k;
        val = 32'd0;
        repeat (8 * SCAN_DIV + 2) begin
            tick();
            for (int k = 0; k < 8; k++) begin
                an_k = ~(8'b1 << k);
                if (disp_an == an_k) begin
                    for (int j = 0; j < 16; j++) begin
                        if (disp_seg[6:0] == font[j]) val[4*k +: 4] = 4'(j);
                    end
                end
            end
        end
    endtask

    task automatic step_idx();
        exp_idx = (exp_idx + 1) % 32;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [4:0]  prev_sel;
        logic        sel_ok;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        reset     = 1'b0;
        mode_auto = 1'b0;
        step_btn  = 1'b0;
        freeze    = 1'b0;
        use_ovr   = 1'b1;
        ovr_val   = 32'h1234ABCD;
        #1;
        do_reset(1'b0);
        $display("reset released: reg_sel=%0d an=%h seg=%h", reg_sel, disp_an, disp_seg);

        // Idle display of a known value
        tick();
        tick();
        check("idle_digit0_D", disp_seg, 8'hA1);
        read_display(v);
        check("idle_value", v, 32'h1234ABCD);
        $display("idle display read %h", v);
        use_ovr = 1'b0;

        // Manual stepping through the full wrap and on to 7
        exp_idx = 0;
        for (int p = 0; p < 39; p++) begin
            press();
            step_idx();
            check("manual_sel", reg_sel, exp_idx);
            $display("manual press %0d: reg_sel=%0d", p, reg_sel);
        end

        // Async reset mid-scan with the button held through it
        for (int w = 0; w < 40 && disp_an != 8'hDF; w++) tick();
        check("find_digit5", disp_an, 8'hDF);
        do_reset(1'b1);
        exp_idx = 0;
        repeat (20) tick();
        check("held_btn_no_step", reg_sel, 32'd0);
        step_btn = 1'b0;
        repeat (10) tick();
        press();
        step_idx();
        check("fresh_press", reg_sel, exp_idx);
        $display("after reset, fresh press: reg_sel=%0d", reg_sel);

        // Freeze holds snapshot and index; step during freeze is dropped
        use_ovr = 1'b1;
        ovr_val = 32'hDEADBEEF;
        tick();
        tick();
        freeze  = 1'b1;
        ovr_val = 32'd0;
        press();
        check("freeze_sel", reg_sel, exp_idx);
        read_display(v);
        check("freeze_value", v, 32'hDEADBEEF);
        $display("frozen display read %h reg_sel=%0d", v, reg_sel);
        freeze = 1'b0;
        tick();
        tick();
        check("unfreeze_seg", {25'd0, disp_seg[6:0]}, 32'h40);
        repeat (10) tick();
        check("freeze_pulse_dropped", reg_sel, exp_idx);
        use_ovr = 1'b0;

        // Auto stepping every STEP_DIV edges
        mode_auto = 1'b1;
        for (int p = 0; p < 4; p++) begin
            repeat (STEP_DIV - 1) tick();
            check("auto_hold", reg_sel, exp_idx);
            tick();
            step_idx();
            check("auto_step", reg_sel, exp_idx);
            $display("auto step: reg_sel=%0d", reg_sel);
        end

        // Button pulse coincident with terminal count (pulse lands 5 edges after press)
        repeat (STEP_DIV - 5) tick();
        step_btn = 1'b1;
        repeat (4) tick();
        check("coinc_hold", reg_sel, exp_idx);
        tick();
        step_idx();
        check("coinc_single_step", reg_sel, exp_idx);
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (10) tick();
        check("coinc_restart_hold", reg_sel, exp_idx);
        tick();
        step_idx();
        check("coinc_restart_step", reg_sel, exp_idx);
        $display("coincident press: reg_sel=%0d", reg_sel);

        // Mid-period button press restarts the period
        repeat (3) tick();
        step_btn = 1'b1;
        repeat (4) tick();
        check("mid_hold", reg_sel, exp_idx);
        tick();
        step_idx();
        check("mid_step", reg_sel, exp_idx);
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (10) tick();
        check("mid_restart_hold", reg_sel, exp_idx);
        tick();
        step_idx();
        check("mid_restart_step", reg_sel, exp_idx);
        $display("mid-period press: reg_sel=%0d", reg_sel);

        // Brief switch to manual clears the timer
        repeat (5) tick();
        mode_auto = 1'b0;
        repeat (2) tick();
        mode_auto = 1'b1;
        repeat (STEP_DIV - 1) tick();
        check("mode_hold", reg_sel, exp_idx);
        tick();
        step_idx();
        check("mode_step", reg_sel, exp_idx);
        $display("mode toggle: reg_sel=%0d", reg_sel);

        // Randomised run: display invariants checked every tick
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 99) == 0) mode_auto = ~mode_auto;
            if ($urandom_range(0, 149) == 0) freeze = ~freeze;
            if ($urandom_range(0, 15) == 0) step_btn = ~step_btn;
            regs[$urandom_range(0, 31)] = $urandom;
            prev_sel = reg_sel;
            tick();
            sel_ok = (reg_sel == prev_sel) || (reg_sel == prev_sel + 5'd1);
            check("rand_sel_step", {31'd0, sel_ok}, 32'd1);
            if (c % 2000 == 1999) $display("random cycle %0d: reg_sel=%0d", c + 1, reg_sel);
        end
        freeze   = 1'b0;
        step_btn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
